// File: rtl/synchronous_fifo_mem_2p.sv
// fifo_mem_2p: DEPTH x DATA_WIDTH register array for the FIFO.
// One synchronous write port and one combinational read port. Contents are
// not reset; the FIFO pointers decide which entries hold valid data.
module fifo_mem_2p #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the write word at the addressed entry on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/synchronous_fifo.sv
// synchronous_fifo: single-clock FIFO, DEPTH entries of DATA_WIDTH bits.
// Pointers carry one extra wrap bit so full and empty are told apart when
// the address bits match. Read data is registered (one cycle latency) and
// holds whenever no read is accepted. DEPTH must be a power of two, >= 2.
module synchronous_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  wr_acc, rd_acc;

    // Flags come straight from the registered pointers.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Both accept tests use pre-edge flags: no fall-through when empty,
    // and a simultaneous request while full only reads.
    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    fifo_mem_2p #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Next-state: pointers advance modulo 2*DEPTH via natural PW-bit overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            data_out_d = mem_rdata;
        end
    end

    // Pointer and read-data registers; reset discards stored data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_synchronous_fifo.sv
// Self-checking bench for synchronous_fifo (DEPTH=8, DATA_WIDTH=8).
// A queue models stored words; expected read data is popped on each
// accepted read and compared after the edge.
module tb_synchronous_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int            n_cmp;
    int            n_err;
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] exp_dout;

    synchronous_fifo #(DEPTH, DW) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"},  32'(data_out), 32'(exp_dout));
        chk({tag, ".empty"}, 32'(empty),    32'(sb_q.size() == 0));
        chk({tag, ".full"},  32'(full),     32'(sb_q.size() == DEPTH));
    endtask

    // Drive one cycle from a negedge, update the model at the posedge using
    // pre-edge occupancy, then check at the following negedge.
    task automatic step(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        bit wacc, racc;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        wacc = w && (sb_q.size() < DEPTH);
        racc = r && (sb_q.size() > 0);
        if (racc) exp_dout = sb_q.pop_front();
        if (wacc) sb_q.push_back(d);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_dout = '0;
        rst_n    = 1'b0;
        w_en     = 1'b0;
        r_en     = 1'b0;
        data_in  = '0;

        // Reset state
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle0", 0, 0, 8'h00);
        step("idle1", 0, 0, 8'h00);

        // Fill: full only after the 8th write
        for (int i = 1; i <= 8; i++) step("fill", 1, 0, DW'(i * 8'h11));
        // Overflow guard
        step("ovf", 1, 0, 8'h99);
        // Drain in order, then an underflow read holds 0x88
        for (int i = 0; i < 8; i++) step("drain", 0, 1, 8'h00);
        step("udf", 0, 1, 8'h00);
        chk("udf.hold", 32'(data_out), 32'h88);

        // Wrap-around: write 5, read 5, write 6
        for (int i = 0; i < 5; i++) step("wrap.w5", 1, 0, DW'(8'h30 + i));
        for (int i = 0; i < 5; i++) step("wrap.r5", 0, 1, 8'h00);
        for (int i = 0; i < 6; i++) step("wrap.w6", 1, 0, DW'(8'h40 + i));
        for (int i = 0; i < 3; i++) step("wrap.r3", 0, 1, 8'h00);
        chk("occ3", 32'(sb_q.size()), 32'd3);

        // Simultaneous read/write with 3 entries: occupancy holds
        for (int i = 0; i < 4; i++) step("both", 1, 1, DW'(8'h50 + i));

        // Fill to full, then both requests: read only
        for (int i = 0; i < 5; i++) step("refill", 1, 0, DW'(8'h60 + i));
        step("both.full", 1, 1, 8'hEE);
        // Drain to empty, then both requests: write only, no fall-through
        while (sb_q.size() > 0) step("drain2", 0, 1, 8'h00);
        step("both.empty", 1, 1, 8'h7C);
        step("rd.7c", 0, 1, 8'h00);
        chk("rd.7c.val", 32'(data_out), 32'h7C);

        // Mid-operation reset between edges
        for (int i = 0; i < 4; i++) step("pre.rst", 1, 0, DW'(8'h90 + i));
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        exp_dout = '0;
        #1;
        chk_all("midrst");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("midrst.rel");
        step("post.w", 1, 0, 8'hA5);
        step("post.r", 0, 1, 8'h00);
        chk("post.val", 32'(data_out), 32'hA5);

        // Randomized mix against the model
        for (int i = 0; i < 200; i++)
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/synchronous_fifo.md
Name: synchronous_fifo

Overview:
- Single-clock first-in/first-out buffer, DEPTH entries of DATA_WIDTH bits.
- Decouples a producer (write side) from a consumer (read side) sharing one clock domain.
- Writes are gated by full and reads by empty; read data is registered.

Parameters:
- DEPTH, 8, number of storage entries. Must be a power of two, >= 2. This is positional parameter 1.
- DATA_WIDTH, 8, width of each data word in bits. This is positional parameter 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- w_en  input  1  write request.
- r_en  input  1  read request.
- data_in  input  DATA_WIDTH  write data, sampled at the rising edge when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. The low bits address memory; the MSB is a wrap bit. Both increment modulo 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = low bits equal and MSBs differ.
- full and empty are combinational from the pointers, so they change in the same cycle as the pointer update.
- Write accept: w_en && !full at the rising edge. The memory at wr_ptr low bits takes data_in, and wr_ptr increments.
- Read accept: r_en && !empty at the rising edge. data_out takes the memory at rd_ptr low bits, and rd_ptr increments. Latency is one cycle: the word is visible on data_out after the accepting edge.
- Rejected requests:
  - w_en while full: no memory write, no pointer change.
  - r_en while empty: data_out holds its value, rd_ptr unchanged.
- Simultaneous w_en and r_en: both accept tests use the flags from before the edge.
  - Neither full nor empty: both occur; occupancy is unchanged.
  - When full: only the read occurs.
  - When empty: only the write occurs. The word is not readable until the next cycle; there is no fall-through.
- data_out holds its last value whenever no read is accepted.
- Wrap-around: pointers roll over seamlessly, and the MSB toggle keeps full and empty distinguishable.
- Reset (asynchronous assert, any time including mid-operation): wr_ptr=0, rd_ptr=0, data_out=0, so empty=1 and full=0. Memory contents are not reset and are don't-care. Stored data is discarded.
- Reset release: the first update happens at the next rising edge after rst_n goes high.
- Overflow and underflow are prevented internally; no error outputs.

Decomposition:
- No shared package needed. Pointer width is the local constant $clog2(DEPTH)+1.
- One natural sub-module: fifo_mem_2p. It is a DEPTH x DATA_WIDTH register array with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- Pointer logic, flags and the data_out register stay in synchronous_fifo.

Test Plan:
- Reset: hold rst_n=0 for 15 ns -> data_out=0x00, empty=1, full=0. Release, idle 2 cycles -> flags unchanged.
- Fill: 8 consecutive writes of 0x11, 0x22, ... 0x88 -> empty=0 after the first edge; full=1 after the 8th edge, not before.
- Overflow guard: with full=1, write 0x99 -> full stays 1. A subsequent drain yields no 0x99.
- Drain: 8 consecutive reads -> data_out=0x11, 0x22, ... 0x88, each one cycle after its accepting edge; empty=1 after the 8th. A 9th read leaves data_out=0x88.
- Wrap and simultaneous access:
  - Write 5, read 5, write 6 (pointers wrap) -> data order preserved, flags correct.
  - With 3 entries, assert w_en and r_en together for 4 cycles -> occupancy stays 3, output order correct.
  - Both requests when full -> read only, full=0. Both requests when empty -> write only, empty=0.
- Mid-operation reset: with 4 entries stored, pulse rst_n low between edges -> immediate empty=1, full=0, data_out=0. Then write 0xA5 and read -> data_out=0xA5.
